jimmy_uart_tx: RTL and testbench

Downstream serial output peripheral for the jimmy CPU. It consumes one CPU output port: the out_port byte plus its active-low out_strobe pulse. Accepted bytes are buffered in a small FIFO and shifted out as 8N1 asynchronous serial. It also produces a status byte, wired back to a CPU in_port, so firmware can poll for buffer space.

---
 rtl/jimmy_io_pkg.sv | 19 +
 rtl/jimmy_uart_tx_if.sv | 21 ++
 rtl/jimmy_fifo.sv | 60 ++++++
 rtl/jimmy_uart_tx.sv | 154 +++++++++++++++
 tb/tb_jimmy_uart_tx.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/jimmy_io_pkg.sv
// Shared definitions for the jimmy serial output peripheral:
// one-hot FSM states, default baud divisor and status byte bit positions.
package jimmy_io_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_STOP  = 4'b1000
    } state_t;

    // 100 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    localparam int BUSY_BIT = 0;
    localparam int FULL_BIT = 1;
    localparam int OVF_BIT  = 2;

endpackage

// File: rtl/jimmy_uart_tx_if.sv
// CPU output-port side of the UART transmitter: byte + strobe in,
// serial line and status back out.
interface jimmy_uart_tx_if;
    logic [7:0] data_in;
    logic       strobe_n;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;
    logic [7:0] status;

    modport master (
        output data_in, strobe_n,
        input  tx, busy, full, overflow, status
    );

    modport slave (
        input  data_in, strobe_n,
        output tx, busy, full, overflow, status
    );
endinterface

// File: rtl/jimmy_fifo.sv
// Synchronous first-word-fall-through FIFO, FIFO_DEPTH x 8, with an
// occupancy count; push and pop on the same edge both succeed, even when full.
module jimmy_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          jimmy_clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [7:0]                    din,
    output logic [7:0]                    dout,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge jimmy_clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge jimmy_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/jimmy_uart_tx.sv
// 8N1 serial transmitter fed from a jimmy CPU output port through a small
// FIFO, with a pollable status byte {overflow, full, busy}.
module jimmy_uart_tx
    import jimmy_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          jimmy_clk,
    input  logic          reset,
    jimmy_uart_tx_if.slave bus
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          strobe_reg;
    logic          write_ev;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          overflow_reg;

    state_t        state_reg;
    state_t        state_next;
    logic [BW-1:0] baud_reg;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_idx_reg;
    logic [2:0]    bit_idx_next;
    logic [7:0]    sh_reg;
    logic [7:0]    sh_next;
    logic          tx_reg;
    logic          tx_next;
    logic          baud_tc;
    logic          bit_shift;
    logic          busy;
    logic [7:0]    status_next;

    // Falling edge of the strobe is the write event, so a long low pulse writes once.
    always_ff @(posedge jimmy_clk or negedge reset) begin
        if (!reset) begin
            strobe_reg <= 1'b1;
        end else begin
            strobe_reg <= bus.strobe_n;
        end
    end

    assign write_ev = strobe_reg && !bus.strobe_n;
    assign push     = write_ev && (!fifo_full || pop);

    always_ff @(posedge jimmy_clk or negedge reset) begin
        if (!reset) begin
            overflow_reg <= 1'b0;
        end else if (write_ev && !push) begin
            overflow_reg <= 1'b1;
        end
    end

    jimmy_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .jimmy_clk (jimmy_clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       (bus.data_in),
        .dout      (fifo_dout),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign baud_tc = (baud_reg == BAUD_LAST);

    always_ff @(posedge jimmy_clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:  state_next = fifo_empty ? ST_IDLE : ST_START;
            ST_START: state_next = baud_tc ? ST_DATA : ST_START;
            ST_DATA:  state_next = (baud_tc && bit_idx_reg == 3'd7) ? ST_STOP : ST_DATA;
            ST_STOP:  state_next = baud_tc ? (fifo_empty ? ST_IDLE : ST_START) : ST_STOP;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Popping at the end of a stop bit chains frames with no idle gap.
    always_comb begin
        pop       = ((state_reg == ST_IDLE) || (state_reg == ST_STOP && baud_tc)) && !fifo_empty;
        bit_shift = (state_reg == ST_DATA) && baud_tc;

        baud_next = '0;
        if ((state_reg == ST_START || state_reg == ST_DATA || state_reg == ST_STOP) && !baud_tc) begin
            baud_next = baud_reg + BW'(1);
        end

        sh_next      = sh_reg;
        bit_idx_next = bit_idx_reg;
        if (pop) begin
            sh_next      = fifo_dout;
            bit_idx_next = 3'd0;
        end else if (bit_shift) begin
            sh_next      = {1'b0, sh_reg[7:1]};
            bit_idx_next = bit_idx_reg + 3'd1;
        end

        tx_next = 1'b1;
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = sh_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge jimmy_clk or negedge reset) begin
        if (!reset) begin
            baud_reg    <= '0;
            bit_idx_reg <= 3'd0;
            sh_reg      <= 8'h00;
            tx_reg      <= 1'b1;
        end else begin
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            sh_reg      <= sh_next;
            tx_reg      <= tx_next;
        end
    end

    assign busy = (state_reg != ST_IDLE) || (fifo_count != '0);

    always_comb begin
        status_next           = 8'h00;
        status_next[BUSY_BIT] = busy;
        status_next[FULL_BIT] = fifo_full;
        status_next[OVF_BIT]  = overflow_reg;
    end

    assign bus.tx       = tx_reg;
    assign bus.busy     = busy;
    assign bus.full     = fifo_full;
    assign bus.overflow = overflow_reg;
    assign bus.status   = status_next;

endmodule

// File: tb/tb_jimmy_uart_tx.sv
// Bench for jimmy_uart_tx: every cycle the line and status are compared with a
// frame-schedule model (each accepted byte owns a 10-bit window on the line).
module tb_jimmy_uart_tx;
    localparam int C     = 4;
    localparam int D     = 4;
    localparam int FRAME = 10 * C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    jimmy_uart_tx_if bus();

    jimmy_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .jimmy_clk (clk),
        .reset     (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         m_start[$];
    logic [7:0] m_data[$];
    bit         m_ovf       = 1'b0;
    bit         prev_strobe = 1'b1;

    // Bytes still waiting in the FIFO after edge t (their frame starts later).
    function automatic int pending_after(int t);
        int n = 0;
        foreach (m_start[i]) if (m_start[i] > t) n++;
        return n;
    endfunction

    function automatic void model_write(int w, logic [7:0] d);
        int s;
        if (pending_after(w) < D) begin
            s = w + 1;
            if (m_start.size() > 0 && m_start[$] + FRAME > s) s = m_start[$] + FRAME;
            m_start.push_back(s);
            m_data.push_back(d);
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    function automatic logic exp_tx(int t);
        int k;
        foreach (m_start[i]) begin
            if (t >= m_start[i] && t < m_start[i] + FRAME) begin
                k = (t - m_start[i]) / C;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return m_data[i][k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(int t);
        foreach (m_start[i]) if (m_start[i] + FRAME > t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic f, b;
        b = exp_busy(cyc);
        f = (pending_after(cyc) == D);
        check("tx",       16'(bus.tx),       16'(exp_tx(cyc)));
        check("busy",     16'(bus.busy),     16'(b));
        check("full",     16'(bus.full),     16'(f));
        check("overflow", 16'(bus.overflow), 16'(m_ovf));
        check("status",   16'(bus.status),   16'({5'b0, m_ovf, f, b}));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (!bus.strobe_n && prev_strobe) model_write(cyc, bus.data_in);
            prev_strobe = bus.strobe_n;
        end else begin
            prev_strobe = 1'b1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous assert mid low-phase, synchronous release at a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        m_start.delete();
        m_data.delete();
        m_ovf       = 1'b0;
        prev_strobe = 1'b1;
        #1;
        check("rst_tx",     16'(bus.tx),     16'h0001);
        check("rst_status", 16'(bus.status), 16'h0000);
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic write_byte(logic [7:0] d, int hold, int gap);
        bus.data_in  = d;
        bus.strobe_n = 1'b0;
        repeat (hold) tick();
        bus.strobe_n = 1'b1;
        repeat (gap) tick();
    endtask

    initial begin
        logic [9:0] seen;
        int         p;
        bus.strobe_n = 1'b1;
        bus.data_in  = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: reset in the middle of an all-zero frame, then silence
        write_byte(8'h00, 1, 10);
        check("pre_rst_tx_low", 16'(bus.tx), 16'h0000);
        do_reset();
        repeat (20) tick();

        // 2: single A5 frame, explicit line pattern and busy end
        bus.data_in  = 8'hA5;
        bus.strobe_n = 1'b0;
        tick();
        bus.strobe_n = 1'b1;
        for (int b = 0; b < 10; b++) begin
            tick();
            seen[b] = bus.tx;
            repeat (C - 1) tick();
        end
        check("a5_line", 16'(seen), 16'(10'b1101001010));
        check("a5_busy_last", 16'(bus.busy), 16'h0001);
        tick();
        check("a5_busy_end", 16'(bus.busy), 16'h0000);
        repeat (5) tick();

        // 3: strobe held low for 10 cycles writes once
        write_byte(8'h3C, 10, 60);

        // 4: back-to-back writes two cycles apart
        write_byte(8'h01, 1, 1);
        write_byte(8'h02, 1, 1);
        write_byte(8'h03, 1, 130);

        // 5: six writes into a depth-4 FIFO, one dropped
        for (int i = 0; i < 6; i++) write_byte(8'h10 + 8'(i), 1, 1);
        check("ovf_status", 16'(bus.status), 16'h0007);
        repeat (250) tick();
        check("ovf_sticky", 16'(bus.overflow), 16'h0001);
        do_reset();
        tick();

        // 6: write on the very edge the FSM pops from a full FIFO
        for (int i = 0; i < 5; i++) write_byte(8'h20 + 8'(i), 1, 1);
        check("pre_pop_full", 16'(bus.full), 16'h0001);
        p = m_start[1];
        repeat (FRAME + 4) begin
            if (cyc < p - 1) tick();
        end
        bus.data_in  = 8'h99;
        bus.strobe_n = 1'b0;
        tick();
        bus.strobe_n = 1'b1;
        check("pop_edge_cyc", 16'(cyc), 16'(p));
        check("pop_edge_full", 16'(bus.full), 16'h0001);
        check("pop_edge_ovf",  16'(bus.overflow), 16'h0000);
        repeat (260) tick();

        // random traffic against the model
        for (int i = 0; i < 40; i++) begin
            write_byte(8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 45)));
        end
        repeat (260) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
